// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the instruction cache: controller FSM encoding and
// burst RAM command codes.
package instruction_cache_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWbCmd  = 3'd1,
        StWbData = 3'd2,
        StRdCmd  = 3'd3,
        StRdData = 3'd4
    } cache_state_e;

    localparam logic BrCmdRead  = 1'b0;
    localparam logic BrCmdWrite = 1'b1;

endpackage

// File: rtl/instruction_cache_line_store.sv
// Cache line data storage: byte-enable word writes, whole-beat fill writes,
// two combinational word read ports and one beat-wide eviction read port.
module cache_line_store #(
    parameter int unsigned LINE_IX_BITS = 1,
    parameter int unsigned WORD_IX_BITS = 3,
    parameter int unsigned BEAT_IX_BITS = 2,
    parameter int unsigned WORD_BITS    = 32,
    parameter int unsigned BEAT_BITS    = 64
) (
    input  logic                    clk_i,
    input  logic [WORD_BITS/8-1:0]  a_be_i,
    input  logic [LINE_IX_BITS-1:0] a_line_i,
    input  logic [WORD_IX_BITS-1:0] a_word_i,
    input  logic [WORD_BITS-1:0]    a_wdata_i,
    output logic [WORD_BITS-1:0]    a_rdata_o,
    input  logic [LINE_IX_BITS-1:0] b_line_i,
    input  logic [WORD_IX_BITS-1:0] b_word_i,
    output logic [WORD_BITS-1:0]    b_rdata_o,
    input  logic                    fill_en_i,
    input  logic [LINE_IX_BITS-1:0] fill_line_i,
    input  logic [BEAT_IX_BITS-1:0] fill_beat_i,
    input  logic [BEAT_BITS-1:0]    fill_data_i,
    input  logic [LINE_IX_BITS-1:0] ev_line_i,
    input  logic [BEAT_IX_BITS-1:0] ev_beat_i,
    output logic [BEAT_BITS-1:0]    ev_data_o
);

    localparam int unsigned NumWords     = 1 << (LINE_IX_BITS + WORD_IX_BITS);
    localparam int unsigned SelBits      = WORD_IX_BITS - BEAT_IX_BITS;
    localparam int unsigned WordsPerBeat = 1 << SelBits;
    localparam int unsigned NumBytes     = WORD_BITS / 8;

    logic [WORD_BITS-1:0] mem_q [NumWords];

    // Port A byte writes and fill beats; the controller never aims both at the same line.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NumBytes; b++) begin
            if (a_be_i[b]) begin
                mem_q[{a_line_i, a_word_i}][b*8 +: 8] <= a_wdata_i[b*8 +: 8];
            end
        end
        if (fill_en_i) begin
            // Lower half of a beat lands at the lower word address.
            for (int w = 0; w < WordsPerBeat; w++) begin
                mem_q[{fill_line_i, fill_beat_i, SelBits'(w)}] <=
                    fill_data_i[w*WORD_BITS +: WORD_BITS];
            end
        end
    end

    assign a_rdata_o = mem_q[{a_line_i, a_word_i}];
    assign b_rdata_o = mem_q[{b_line_i, b_word_i}];

    // Assemble one write-back beat from consecutive words of the victim line.
    always_comb begin
        ev_data_o = '0;
        for (int w = 0; w < WordsPerBeat; w++) begin
            ev_data_o[w*WORD_BITS +: WORD_BITS] = mem_q[{ev_line_i, ev_beat_i, SelBits'(w)}];
        end
    end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped write-back cache: port A data (byte writes), port B fetch,
// burst RAM refill/eviction controller. Define CACHE_DEBUG_EN to trace
// misses, evictions and fill completions in simulation.
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int unsigned ADDRESS_BITWIDTH          = 8,
    parameter int unsigned INSTRUCTION_BITWIDTH      = 32,
    parameter int unsigned CACHE_LINE_IX_BITWIDTH    = 1,
    parameter int unsigned CACHE_IX_IN_LINE_BITWIDTH = 3,
    parameter int unsigned RAM_DEPTH_BITWIDTH        = 8,
    parameter int unsigned RAM_BURST_DATA_COUNT      = 4,
    parameter int unsigned RAM_BURST_DATA_BITWIDTH   = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [INSTRUCTION_BITWIDTH/8-1:0]    weA,
    input  logic [ADDRESS_BITWIDTH-1:0]          addrA,
    input  logic [INSTRUCTION_BITWIDTH-1:0]      dinA,
    output logic [INSTRUCTION_BITWIDTH-1:0]      doutA,
    input  logic [ADDRESS_BITWIDTH-1:0]          addrB,
    output logic [INSTRUCTION_BITWIDTH-1:0]      doutB,
    output logic                                 rdyB,
    output logic                                 bsyB,
    output logic                                 br_cmd,
    output logic                                 br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    input  logic                                 br_rd_data_valid,
    input  logic                                 br_busy
);

    localparam int unsigned WordByteBits  = $clog2(INSTRUCTION_BITWIDTH / 8);
    localparam int unsigned LineBits      = CACHE_LINE_IX_BITWIDTH;
    localparam int unsigned WordBits      = CACHE_IX_IN_LINE_BITWIDTH;
    localparam int unsigned TagBits       = ADDRESS_BITWIDTH - LineBits - WordBits - WordByteBits;
    localparam int unsigned NumLines      = 1 << LineBits;
    localparam int unsigned BeatIxBits    = $clog2(RAM_BURST_DATA_COUNT);
    localparam int unsigned BeatByteBits  = $clog2(RAM_BURST_DATA_BITWIDTH / 8);
    localparam int unsigned LineBeatShift = WordBits + WordByteBits - BeatByteBits;
    localparam logic [BeatIxBits-1:0] LastBeat = BeatIxBits'(RAM_BURST_DATA_COUNT - 1);

    // Beat-aligned RAM address of a line's first beat.
    function automatic logic [RAM_DEPTH_BITWIDTH-1:0] beat_addr(input logic [TagBits-1:0] tag,
                                                                input logic [LineBits-1:0] line);
        beat_addr = RAM_DEPTH_BITWIDTH'({tag, line}) << LineBeatShift;
    endfunction

    cache_state_e                         state_q;
    logic [TagBits-1:0]                   tag_q [NumLines];
    logic [NumLines-1:0]                  valid_q, dirty_q;
    logic [TagBits-1:0]                   tgt_tag_q;
    logic [LineBits-1:0]                  tgt_line_q;
    logic [BeatIxBits-1:0]                beat_q;
    logic                                 cmd_en_q, cmd_q;
    logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr_q;
    logic [RAM_BURST_DATA_BITWIDTH-1:0]   wr_data_q;

    logic [TagBits-1:0]                   tag_a, tag_b, miss_tag;
    logic [LineBits-1:0]                  line_a, line_b, miss_line, ev_line;
    logic [WordBits-1:0]                  word_a, word_b;
    logic [BeatIxBits-1:0]                ev_beat;
    logic [RAM_BURST_DATA_BITWIDTH-1:0]   ev_data;
    logic                                 hit_a, hit_b, busy, launch, a_wr_en, fill_en;
    logic [INSTRUCTION_BITWIDTH/8-1:0]    a_be;
    logic                                 unused_byte_bits;

    assign {tag_a, line_a, word_a} = addrA[ADDRESS_BITWIDTH-1:WordByteBits];
    assign {tag_b, line_b, word_b} = addrB[ADDRESS_BITWIDTH-1:WordByteBits];
    assign unused_byte_bits = ^{addrA[WordByteBits-1:0], addrB[WordByteBits-1:0]};

    assign hit_a  = valid_q[line_a] && (tag_q[line_a] == tag_a);
    assign hit_b  = valid_q[line_b] && (tag_q[line_b] == tag_b);
    assign busy   = (state_q != StIdle);
    assign launch = !busy && !br_busy && (!hit_b || !hit_a);

    // Port B misses take priority over port A misses.
    always_comb begin
        miss_tag  = tag_b;
        miss_line = line_b;
        if (hit_b) begin
            miss_tag  = tag_a;
            miss_line = line_a;
        end
    end

    assign ev_line = busy ? tgt_line_q : miss_line;
    assign ev_beat = busy ? beat_q + BeatIxBits'(1) : '0;

    // Writes to the line being evicted or refilled would be lost, so they are dropped.
    assign a_wr_en = rst && (|weA) && hit_a && !((busy || launch) && (line_a == ev_line));
    assign a_be    = a_wr_en ? weA : '0;
    assign fill_en = (state_q == StRdData) && br_rd_data_valid;

    cache_line_store #(
        .LINE_IX_BITS (LineBits),
        .WORD_IX_BITS (WordBits),
        .BEAT_IX_BITS (BeatIxBits),
        .WORD_BITS    (INSTRUCTION_BITWIDTH),
        .BEAT_BITS    (RAM_BURST_DATA_BITWIDTH)
    ) u_store (
        .clk_i       (clk),
        .a_be_i      (a_be),
        .a_line_i    (line_a),
        .a_word_i    (word_a),
        .a_wdata_i   (dinA),
        .a_rdata_o   (doutA),
        .b_line_i    (line_b),
        .b_word_i    (word_b),
        .b_rdata_o   (doutB),
        .fill_en_i   (fill_en),
        .fill_line_i (tgt_line_q),
        .fill_beat_i (beat_q),
        .fill_data_i (br_rd_data),
        .ev_line_i   (ev_line),
        .ev_beat_i   (ev_beat),
        .ev_data_o   (ev_data)
    );

    // Controller FSM with line metadata and registered RAM command outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            tag_q      <= '{default: '0};
            valid_q    <= '0;
            dirty_q    <= '0;
            tgt_tag_q  <= '0;
            tgt_line_q <= '0;
            beat_q     <= '0;
            cmd_en_q   <= 1'b0;
            cmd_q      <= BrCmdRead;
            br_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            cmd_en_q <= 1'b0;
            if (a_wr_en) dirty_q[line_a] <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (launch) begin
                        tgt_tag_q  <= miss_tag;
                        tgt_line_q <= miss_line;
                        beat_q     <= '0;
                        cmd_en_q   <= 1'b1;
                        if (valid_q[miss_line] && dirty_q[miss_line]) begin
                            state_q   <= StWbCmd;
                            cmd_q     <= BrCmdWrite;
                            br_addr_q <= beat_addr(tag_q[miss_line], miss_line);
                            wr_data_q <= ev_data;
                        end else begin
                            state_q   <= StRdCmd;
                            cmd_q     <= BrCmdRead;
                            br_addr_q <= beat_addr(miss_tag, miss_line);
                        end
                    end
                end
                StWbCmd: begin
                    wr_data_q <= ev_data;
                    beat_q    <= ev_beat;
                    state_q   <= StWbData;
                end
                StWbData: begin
                    if (beat_q == LastBeat) begin
                        state_q   <= StRdCmd;
                        cmd_en_q  <= 1'b1;
                        cmd_q     <= BrCmdRead;
                        br_addr_q <= beat_addr(tgt_tag_q, tgt_line_q);
                    end else begin
                        wr_data_q <= ev_data;
                        beat_q    <= ev_beat;
                    end
                end
                StRdCmd: begin
                    valid_q[tgt_line_q] <= 1'b0;
                    beat_q              <= '0;
                    state_q             <= StRdData;
                end
                StRdData: begin
                    if (br_rd_data_valid) begin
                        beat_q <= beat_q + BeatIxBits'(1);
                        if (beat_q == LastBeat) begin
                            tag_q[tgt_line_q]   <= tgt_tag_q;
                            valid_q[tgt_line_q] <= 1'b1;
                            dirty_q[tgt_line_q] <= 1'b0;
                            state_q             <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rdyB         = hit_b;
    assign bsyB         = busy;
    assign br_cmd       = cmd_q;
    assign br_cmd_en    = cmd_en_q;
    assign br_addr      = br_addr_q;
    assign br_wr_data   = wr_data_q;
    assign br_data_mask = '0;

`ifdef CACHE_DEBUG_EN
    // Simulation trace of controller events.
    always @(posedge clk) begin
        if (rst && launch) begin
            $display("icache: miss addr=%h line=%0d tag=%0d", hit_b ? addrA : addrB,
                     miss_line, miss_tag);
            if (valid_q[miss_line] && dirty_q[miss_line])
                $display("icache: evict line=%0d tag=%0d", miss_line, tag_q[miss_line]);
        end
        if (rst && fill_en && beat_q == LastBeat)
            $display("icache: fill done line=%0d tag=%0d", tgt_line_q, tgt_tag_q);
    end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a 3-cycle-latency burst RAM model.
module tb_instruction_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  weA;
    logic [7:0]  addrA, addrB;
    logic [31:0] dinA, doutA, doutB;
    logic        rdyB, bsyB, br_cmd, br_cmd_en, br_rd_data_valid, br_busy;
    logic [7:0]  br_addr, br_data_mask;
    logic [63:0] br_wr_data, br_rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instruction_cache dut (
        .clk              (clk),
        .rst              (rst),
        .weA              (weA),
        .addrA            (addrA),
        .dinA             (dinA),
        .doutA            (doutA),
        .addrB            (addrB),
        .doutB            (doutB),
        .rdyB             (rdyB),
        .bsyB             (bsyB),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_wr_data       (br_wr_data),
        .br_data_mask     (br_data_mask),
        .br_rd_data       (br_rd_data),
        .br_rd_data_valid (br_rd_data_valid),
        .br_busy          (br_busy)
    );

    // ---------------- RAM model ----------------
    function automatic logic [63:0] ram_init(input int i);
        case (i)
            0:       ram_init = 64'h3F5A2E14_B7C6A980;
            1:       ram_init = 64'hA5A50003_AB4C3E6F;
            4:       ram_init = 64'hA5A50009_2F5E3C7A;
            8:       ram_init = 64'hA5A50011_4E5F6A7B;
            default: ram_init = {32'hA5A5_0000 + 32'(2*i+1), 32'hA5A5_0000 + 32'(2*i)};
        endcase
    endfunction

    logic [63:0] ram_q [256];
    bit          ram_w [256];
    int          rd_cnt = 0, wr_cnt = 0;
    logic [7:0]  rd_base, wr_base;
    bit          cmd_log [$];

    function automatic logic [63:0] ram_rd(input int i);
        ram_rd = ram_w[i] ? ram_q[i] : ram_init(i);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] mask);
        merge = old;
        for (int b = 0; b < 8; b++) if (!mask[b]) merge[b*8 +: 8] = nw[b*8 +: 8];
    endfunction

    assign br_busy = (rd_cnt != 0) || (wr_cnt != 0);

    always @(posedge clk) begin : ram_model
        int wa;
        br_rd_data_valid <= 1'b0;
        if (br_cmd_en) cmd_log.push_back(br_cmd);
        if (br_cmd_en && br_cmd) begin
            ram_q[br_addr] <= merge(ram_rd(int'(br_addr)), br_wr_data, br_data_mask);
            ram_w[br_addr] <= 1'b1;
            wr_base        <= br_addr;
            wr_cnt         <= 1;
        end else if (wr_cnt != 0) begin
            wa = (int'(wr_base) + wr_cnt) % 256;
            ram_q[wa] <= merge(ram_rd(wa), br_wr_data, br_data_mask);
            ram_w[wa] <= 1'b1;
            wr_cnt    <= (wr_cnt == 3) ? 0 : wr_cnt + 1;
        end
        if (br_cmd_en && !br_cmd) begin
            rd_base <= br_addr;
            rd_cnt  <= 1;
        end else if (rd_cnt != 0) begin
            if (rd_cnt >= 3) begin
                br_rd_data_valid <= 1'b1;
                br_rd_data       <= ram_rd((int'(rd_base) + rd_cnt - 3) % 256);
            end
            rd_cnt <= (rd_cnt == 6) ? 0 : rd_cnt + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_ready(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            @(negedge clk);
            if (rdyB === 1'b1 && bsyB === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic set_addr(input logic [7:0] a);
        addrA = a;
        addrB = a;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; weA = 4'h0; dinA = 32'h0; set_addr(8'h00);
        repeat (2) @(negedge clk);
        n_checks++; if (rdyB !== 1'b0) begin n_fail++; $display("FAIL reset_rdyB: got %b want 0", rdyB); end
        n_checks++; if (bsyB !== 1'b0) begin n_fail++; $display("FAIL reset_bsyB: got %b want 0", bsyB); end
        n_checks++; if (br_cmd_en !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_en: got %b want 0", br_cmd_en); end
        n_checks++; if (br_cmd !== 1'b0) begin n_fail++; $display("FAIL reset_cmd: got %b want 0", br_cmd); end
        n_checks++; if (br_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", br_addr); end
        n_checks++; if (br_data_mask !== 8'h00) begin n_fail++; $display("FAIL reset_mask: got %h want 00", br_data_mask); end
    endtask

    task automatic test_first_fill();
        int beats;
        bit seen;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bsyB !== 1'b1) begin n_fail++; $display("FAIL fill0_bsy: got %b want 1", bsyB); end
        n_checks++; if ({br_cmd_en, br_cmd, br_addr} !== {2'b10, 8'h00}) begin
            n_fail++; $display("FAIL fill0_cmd: got en=%b cmd=%b addr=%h want en=1 cmd=0 addr=00", br_cmd_en, br_cmd, br_addr); end
        beats = 0; seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (br_rd_data_valid === 1'b1) beats++;
            if (beats == 4) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL fill0_beats: got %0d beats want 4", beats); end
        n_checks++; if (rdyB !== 1'b0) begin n_fail++; $display("FAIL fill0_rdy_early: got %b want 0", rdyB); end
        @(negedge clk);
        n_checks++; if ({rdyB, bsyB} !== 2'b10) begin n_fail++; $display("FAIL fill0_done: got rdy=%b bsy=%b want 1 0", rdyB, bsyB); end
        n_checks++; if (doutB !== 32'hB7C6A980) begin n_fail++; $display("FAIL fill0_doutB: got %h want B7C6A980", doutB); end
    endtask

    task automatic test_hit();
        int n;
        n = cmd_log.size();
        set_addr(8'h04);
        for (int i = 0; i < 2 && rdyB !== 1'b1; i++) @(negedge clk);
        #1;
        n_checks++; if ({rdyB, bsyB} !== 2'b10) begin n_fail++; $display("FAIL hit4_flags: got rdy=%b bsy=%b want 1 0", rdyB, bsyB); end
        n_checks++; if (doutB !== 32'h3F5A2E14) begin n_fail++; $display("FAIL hit4_doutB: got %h want 3F5A2E14", doutB); end
        @(negedge clk);
        set_addr(8'h08);
        #1;
        n_checks++; if (doutB !== 32'hAB4C3E6F) begin n_fail++; $display("FAIL hit8_doutB: got %h want AB4C3E6F", doutB); end
        n_checks++; if (doutA !== 32'hAB4C3E6F) begin n_fail++; $display("FAIL hit8_doutA: got %h want AB4C3E6F", doutA); end
        repeat (3) @(negedge clk);
        n_checks++; if (cmd_log.size() != n) begin n_fail++; $display("FAIL hit_no_cmd: got %0d cmds want %0d", cmd_log.size(), n); end
    endtask

    task automatic test_fill(input string name, input logic [7:0] a, input logic [7:0] exp_baddr,
                             input logic [31:0] exp_data);
        bit ok;
        set_addr(a);
        @(negedge clk);
        n_checks++; if ({br_cmd_en, br_cmd, br_addr} !== {2'b10, exp_baddr}) begin
            n_fail++; $display("FAIL %s_cmd: got en=%b cmd=%b addr=%h want en=1 cmd=0 addr=%h", name, br_cmd_en, br_cmd, br_addr, exp_baddr); end
        wait_ready(40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL %s_timeout: got no rdyB want rdyB=1", name); end
        n_checks++; if (doutB !== exp_data) begin n_fail++; $display("FAIL %s_doutB: got %h want %h", name, doutB, exp_data); end
    endtask

    task automatic test_write_evict();
        bit ok;
        set_addr(8'd64); weA = 4'b0011; dinA = 32'h1234_5678;
        #1;
        n_checks++; if (doutA !== 32'h4E5F6A7B) begin n_fail++; $display("FAIL wr_pre_doutA: got %h want 4E5F6A7B", doutA); end
        @(negedge clk);
        weA = 4'h0;
        #1;
        n_checks++; if (doutA !== 32'h4E5F5678) begin n_fail++; $display("FAIL wr_doutA: got %h want 4E5F5678", doutA); end
        n_checks++; if (bsyB !== 1'b0) begin n_fail++; $display("FAIL wr_bsy: got %b want 0", bsyB); end
        cmd_log.delete();
        set_addr(8'd0);
        @(negedge clk);
        n_checks++; if ({br_cmd_en, br_cmd, br_addr} !== {2'b11, 8'h08}) begin
            n_fail++; $display("FAIL wb_cmd: got en=%b cmd=%b addr=%h want en=1 cmd=1 addr=08", br_cmd_en, br_cmd, br_addr); end
        n_checks++; if (br_wr_data !== 64'hA5A50011_4E5F5678) begin
            n_fail++; $display("FAIL wb_beat0: got %h want A5A500114E5F5678", br_wr_data); end
        wait_ready(50, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL evict_timeout: got no rdyB want rdyB=1"); end
        n_checks++; if (cmd_log.size() != 2 || cmd_log[0] !== 1'b1 || cmd_log[1] !== 1'b0) begin
            n_fail++; $display("FAIL evict_order: got %0d cmds want write then read", cmd_log.size()); end
        n_checks++; if (ram_rd(8) !== 64'hA5A50011_4E5F5678) begin n_fail++; $display("FAIL wb_ram8: got %h want A5A500114E5F5678", ram_rd(8)); end
        n_checks++; if (ram_rd(9) !== 64'hA5A50013_A5A50012) begin n_fail++; $display("FAIL wb_ram9: got %h want A5A50013A5A50012", ram_rd(9)); end
        n_checks++; if (ram_rd(11) !== 64'hA5A50017_A5A50016) begin n_fail++; $display("FAIL wb_ram11: got %h want A5A50017A5A50016", ram_rd(11)); end
        n_checks++; if (doutB !== 32'hB7C6A980) begin n_fail++; $display("FAIL evict_doutB: got %h want B7C6A980", doutB); end
        cmd_log.delete();
        set_addr(8'd64);
        wait_ready(40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL reread_timeout: got no rdyB want rdyB=1"); end
        n_checks++; if (doutA !== 32'h4E5F5678) begin n_fail++; $display("FAIL reread_doutA: got %h want 4E5F5678", doutA); end
        n_checks++; if (cmd_log.size() != 1 || cmd_log[0] !== 1'b0) begin
            n_fail++; $display("FAIL reread_clean: got %0d cmds want one read", cmd_log.size()); end
    endtask

    task automatic test_reset_mid_fill();
        bit ok;
        set_addr(8'd96);
        @(negedge clk);
        n_checks++; if (br_addr !== 8'd12) begin n_fail++; $display("FAIL rst_fill_addr: got %h want 0c", br_addr); end
        @(negedge clk);
        n_checks++; if (bsyB !== 1'b1) begin n_fail++; $display("FAIL rst_fill_bsy: got %b want 1", bsyB); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_checks++; if ({rdyB, bsyB, br_cmd_en} !== 3'b000) begin
            n_fail++; $display("FAIL rst_abort: got rdy=%b bsy=%b en=%b want 0 0 0", rdyB, bsyB, br_cmd_en); end
        wait_ready(60, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_refill_timeout: got no rdyB want rdyB=1"); end
        n_checks++; if (doutB !== 32'hA5A50018) begin n_fail++; $display("FAIL rst_refill_doutB: got %h want A5A50018", doutB); end
        n_checks++; if (doutA !== 32'hA5A50018) begin n_fail++; $display("FAIL rst_refill_doutA: got %h want A5A50018", doutA); end
    endtask

    initial begin
        test_reset();
        test_first_fill();
        test_hit();
        test_fill("tag1_line0", 8'd64, 8'd8, 32'h4E5F6A7B);
        test_fill("line1", 8'd32, 8'd4, 32'h2F5E3C7A);
        test_write_evict();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
